// File: rtl/tage_tagged_bank.sv
// TAGE tagged component: {valid, tag, ctr, u} per entry,
// one registered lookup and one update per cycle, periodic u-aging sweep.
module tage_tagged_bank #(
  parameter int unsigned NrEntries    = 256,
  parameter int unsigned TagBits      = 8,
  parameter int unsigned CtrBits      = 3,
  parameter int unsigned UBits        = 2,
  parameter int unsigned UResetPeriod = 2048,
  localparam int unsigned IdxBits     = $clog2(NrEntries),
  localparam int unsigned PerBits     = $clog2(UResetPeriod)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lookup_valid_i,
  input  logic [IdxBits-1:0] lookup_index_i,
  input  logic [TagBits-1:0] lookup_tag_i,
  output logic               lookup_valid_o,
  output logic               lookup_hit_o,
  output logic               lookup_taken_o,
  output logic               lookup_weak_o,
  output logic [UBits-1:0]   lookup_u_o,
  input  logic               update_valid_i,
  output logic               update_ready_o,
  input  logic [IdxBits-1:0] update_index_i,
  input  logic [TagBits-1:0] update_tag_i,
  input  logic               update_alloc_i,
  input  logic               update_taken_i,
  input  logic               update_u_inc_i,
  input  logic               update_u_dec_i,
  output logic               sweep_active_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  // Counter kept offset-binary: MSB is the direction,
  // 100..0 / 011..1 are the weak states around zero.
  localparam logic [CtrBits-1:0] CtrWT  = {1'b1, {(CtrBits-1){1'b0}}};
  localparam logic [CtrBits-1:0] CtrWN  = {1'b0, {(CtrBits-1){1'b1}}};
  localparam logic [CtrBits-1:0] CtrMax = '1;
  localparam logic [CtrBits-1:0] CtrMin = '0;
  localparam logic [UBits-1:0]   UMax   = '1;
  localparam logic [UBits-1:0]   UMsb   = {1'b1, {(UBits-1){1'b0}}};
  localparam logic [UBits-1:0]   ULsb   = UBits'(1);
  localparam logic [PerBits-1:0] PerLast = PerBits'(UResetPeriod - 1);
  localparam logic [IdxBits-1:0] PtrLast = IdxBits'(NrEntries - 1);

  logic [NrEntries-1:0] valid_q;
  logic [TagBits-1:0]   tag_q [NrEntries];
  logic [CtrBits-1:0]   ctr_q [NrEntries];
  logic [UBits-1:0]     u_q   [NrEntries];

  logic [0:0]         state_q, state_d;
  logic [PerBits-1:0] per_q, per_d;
  logic [IdxBits-1:0] ptr_q, ptr_d;
  logic               phase_q, phase_d;

  logic               lk_valid_q, lk_hit_q, lk_taken_q, lk_weak_q;
  logic [UBits-1:0]   lk_u_q;

  logic               upd_fire, upd_hit, upd_write;
  logic [CtrBits-1:0] ctr_cur, ctr_upd_d;
  logic [UBits-1:0]   u_cur, u_upd_d, sweep_u_d;
  logic               lk_match;
  logic [CtrBits-1:0] lk_ctr;

  assign update_ready_o = (state_q == StIdle);
  assign sweep_active_o = (state_q == StSweep);

  assign upd_fire  = update_valid_i && update_ready_o;
  assign upd_hit   = valid_q[update_index_i] &&
                     (tag_q[update_index_i] == update_tag_i);
  assign upd_write = upd_fire && (update_alloc_i || upd_hit);
  assign ctr_cur   = ctr_q[update_index_i];
  assign u_cur     = u_q[update_index_i];

  assign lk_match = valid_q[lookup_index_i] &&
                    (tag_q[lookup_index_i] == lookup_tag_i);
  assign lk_ctr   = ctr_q[lookup_index_i];

  assign sweep_u_d = u_q[ptr_q] & ~(phase_q ? ULsb : UMsb);

  // Saturating prediction counter next value for the update port
  always_comb begin
    ctr_upd_d = ctr_cur;
    if (update_alloc_i) begin
      ctr_upd_d = update_taken_i ? CtrWT : CtrWN;
    end else if (update_taken_i) begin
      if (ctr_cur != CtrMax) ctr_upd_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != CtrMin) ctr_upd_d = ctr_cur - 1'b1;
    end
  end

  // Saturating useful counter next value for the update port
  always_comb begin
    u_upd_d = u_cur;
    if (update_alloc_i) begin
      u_upd_d = '0;
    end else if (update_u_inc_i && !update_u_dec_i) begin
      if (u_cur != UMax) u_upd_d = u_cur + 1'b1;
    end else if (update_u_dec_i && !update_u_inc_i) begin
      if (u_cur != '0) u_upd_d = u_cur - 1'b1;
    end
  end

  // Period counting and sweep sequencing
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    ptr_d   = ptr_q;
    phase_d = phase_q;
    if (state_q == StSweep) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PtrLast) begin
        state_d = StIdle;
        phase_d = ~phase_q;
      end
    end else if (upd_fire) begin
      if (per_q == PerLast) begin
        per_d   = '0;
        ptr_d   = '0;
        state_d = StSweep;
      end else begin
        per_d = per_q + 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      per_q   <= '0;
      ptr_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
    end
  end

  // Valid and useful bits: update writes, sweep ages u
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NrEntries); i++) u_q[i] <= '0;
    end else begin
      if (upd_write) begin
        valid_q[update_index_i] <= 1'b1;
        u_q[update_index_i]     <= u_upd_d;
      end
      if (state_q == StSweep) u_q[ptr_q] <= sweep_u_d;
    end
  end

  // Tag and prediction counter payload
  always_ff @(posedge clk_i) begin
    if (upd_fire && update_alloc_i) tag_q[update_index_i] <= update_tag_i;
    if (upd_write) ctr_q[update_index_i] <= ctr_upd_d;
  end

  // Registered lookup result, pre-write contents
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_taken_q <= 1'b0;
      lk_weak_q  <= 1'b0;
      lk_u_q     <= '0;
    end else begin
      lk_valid_q <= lookup_valid_i;
      lk_hit_q   <= lookup_valid_i && lk_match;
      lk_taken_q <= lookup_valid_i && lk_match && lk_ctr[CtrBits-1];
      lk_weak_q  <= lookup_valid_i && lk_match &&
                    ((lk_ctr == CtrWT) || (lk_ctr == CtrWN));
      lk_u_q     <= lookup_valid_i ? u_q[lookup_index_i] : '0;
    end
  end

  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_hit_q;
  assign lookup_taken_o = lk_taken_q;
  assign lookup_weak_o  = lk_weak_q;
  assign lookup_u_o     = lk_u_q;

endmodule

// File: tb/tb_tage_tagged_bank.sv
// Bench for tage_tagged_bank: signed-counter behavioural model,
// per-cycle compare, directed literal checks plus random traffic.
module tb_tage_tagged_bank;

  localparam int NE  = 256;
  localparam int PER = 2048;
  localparam int UB  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lookup_valid_i = 1'b0;
  logic [7:0] lookup_index_i = '0;
  logic [7:0] lookup_tag_i = '0;
  logic       lookup_valid_o, lookup_hit_o, lookup_taken_o, lookup_weak_o;
  logic [1:0] lookup_u_o;
  logic       update_valid_i = 1'b0;
  logic       update_ready_o;
  logic [7:0] update_index_i = '0;
  logic [7:0] update_tag_i = '0;
  logic       update_alloc_i = 1'b0;
  logic       update_taken_i = 1'b0;
  logic       update_u_inc_i = 1'b0;
  logic       update_u_dec_i = 1'b0;
  logic       sweep_active_o;

  tage_tagged_bank dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_valid_i(lookup_valid_i), .lookup_index_i(lookup_index_i),
    .lookup_tag_i(lookup_tag_i), .lookup_valid_o(lookup_valid_o),
    .lookup_hit_o(lookup_hit_o), .lookup_taken_o(lookup_taken_o),
    .lookup_weak_o(lookup_weak_o), .lookup_u_o(lookup_u_o),
    .update_valid_i(update_valid_i), .update_ready_o(update_ready_o),
    .update_index_i(update_index_i), .update_tag_i(update_tag_i),
    .update_alloc_i(update_alloc_i), .update_taken_i(update_taken_i),
    .update_u_inc_i(update_u_inc_i), .update_u_dec_i(update_u_dec_i),
    .sweep_active_o(sweep_active_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_upd = 0;

  // Model: ctr as signed integer -4..3, taken when >= 0
  bit         m_en = 0;
  bit         m_valid [NE];
  logic [7:0] m_tag [NE];
  int         m_ctr [NE];
  int         m_u [NE];
  bit         m_sweep = 0;
  int         m_per = 0, m_ptr = 0, m_phase = 0;
  bit         e_lv = 0, e_hit = 0, e_tk = 0, e_wk = 0;
  int         e_u = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model advances on each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] = 0;
        m_u[i] = 0;
      end
      m_sweep = 0; m_per = 0; m_ptr = 0; m_phase = 0;
      e_lv = 0; e_hit = 0; e_tk = 0; e_wk = 0; e_u = 0;
      m_en = 1;
    end else begin
      int li, ui, c;
      bit h;
      li = int'(lookup_index_i);
      h = lookup_valid_i && m_valid[li] && (m_tag[li] == lookup_tag_i);
      e_lv = lookup_valid_i;
      e_hit = h;
      e_tk = h && (m_ctr[li] >= 0);
      e_wk = h && (m_ctr[li] == 0 || m_ctr[li] == -1);
      e_u = m_u[li];
      if (m_sweep) begin
        if (m_phase == 0) m_u[m_ptr] = m_u[m_ptr] % (1 << (UB - 1));
        else m_u[m_ptr] = m_u[m_ptr] - (m_u[m_ptr] % 2);
        m_ptr++;
        if (m_ptr == NE) begin
          m_sweep = 0;
          m_phase = 1 - m_phase;
        end
      end else if (update_valid_i) begin
        ui = int'(update_index_i);
        if (update_alloc_i) begin
          m_valid[ui] = 1;
          m_tag[ui] = update_tag_i;
          m_u[ui] = 0;
          m_ctr[ui] = update_taken_i ? 0 : -1;
        end else if (m_valid[ui] && m_tag[ui] == update_tag_i) begin
          c = m_ctr[ui] + (update_taken_i ? 1 : -1);
          m_ctr[ui] = (c > 3) ? 3 : (c < -4) ? -4 : c;
          if (update_u_inc_i && !update_u_dec_i && m_u[ui] < 3) m_u[ui]++;
          if (update_u_dec_i && !update_u_inc_i && m_u[ui] > 0) m_u[ui]--;
        end
        m_per++;
        if (m_per == PER) begin
          m_per = 0;
          m_sweep = 1;
          m_ptr = 0;
        end
      end
    end
  end

  // Compare process: DUT outputs against model every cycle
  always @(negedge clk) begin
    if (m_en) begin
      chk("ready", int'(update_ready_o), int'(!m_sweep));
      chk("sweep_active", int'(sweep_active_o), int'(m_sweep));
      chk("lk_valid", int'(lookup_valid_o), int'(e_lv));
      if (e_lv) begin
        chk("lk_hit", int'(lookup_hit_o), int'(e_hit));
        chk("lk_u", int'(lookup_u_o), e_u);
      end
      if (e_hit) begin
        chk("lk_taken", int'(lookup_taken_o), int'(e_tk));
        chk("lk_weak", int'(lookup_weak_o), int'(e_wk));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic look(input int idx, input int tag);
    lookup_valid_i = 1'b1;
    lookup_index_i = 8'(idx);
    lookup_tag_i = 8'(tag);
    step();
    lookup_valid_i = 1'b0;
  endtask

  task automatic upd(input int idx, input int tag, input bit al,
                     input bit tk, input bit inc, input bit dec);
    int b;
    b = 0;
    while (m_sweep && b < 2000) begin
      step();
      b++;
    end
    if (b >= 2000) chk("upd_wait_timeout", b, 0);
    update_valid_i = 1'b1;
    update_index_i = 8'(idx);
    update_tag_i = 8'(tag);
    update_alloc_i = al;
    update_taken_i = tk;
    update_u_inc_i = inc;
    update_u_dec_i = dec;
    step();
    update_valid_i = 1'b0;
    n_upd++;
  endtask

  task automatic rnd_upd();
    int idx;
    idx = int'($urandom_range(0, 15));
    if (idx == 5) idx = 6;
    lookup_valid_i = 1'($urandom);
    lookup_index_i = 8'($urandom_range(0, 15));
    lookup_tag_i = 8'($urandom_range(0, 3));
    upd(idx, int'($urandom_range(0, 3)), ($urandom % 4) == 0,
        1'($urandom), 1'($urandom), 1'($urandom));
    lookup_valid_i = 1'b0;
  endtask

  task automatic run_sweep(output int n);
    n = 0;
    while (sweep_active_o && n < 1000) begin
      lookup_valid_i = 1'($urandom);
      lookup_index_i = 8'($urandom);
      lookup_tag_i = 8'($urandom_range(0, 3));
      update_valid_i = 1'b1;
      update_index_i = 8'($urandom_range(6, 15));
      update_tag_i = 8'($urandom_range(0, 3));
      update_alloc_i = 1'b1;
      step();
      n++;
    end
    update_valid_i = 1'b0;
    update_alloc_i = 1'b0;
    lookup_valid_i = 1'b0;
  endtask

  initial begin
    int n0, n;
    step();
    step();
    rst_n = 1'b1;
    n_upd = 0;
    // T1
    look(5, 8'h3A);
    chk("t1_valid", int'(lookup_valid_o), 1);
    chk("t1_hit", int'(lookup_hit_o), 0);
    chk("t1_u", int'(lookup_u_o), 0);
    // T2
    upd(5, 8'h3A, 1, 1, 0, 0);
    look(5, 8'h3A);
    chk("t2_hit", int'(lookup_hit_o), 1);
    chk("t2_taken", int'(lookup_taken_o), 1);
    chk("t2_weak", int'(lookup_weak_o), 1);
    repeat (2) upd(5, 8'h3A, 0, 1, 0, 0);
    look(5, 8'h3A);
    chk("t2_strong_taken", int'(lookup_taken_o), 1);
    chk("t2_strong_weak", int'(lookup_weak_o), 0);
    repeat (7) upd(5, 8'h3A, 0, 0, 0, 0);
    look(5, 8'h3A);
    chk("t2_sat_taken", int'(lookup_taken_o), 0);
    chk("t2_sat_weak", int'(lookup_weak_o), 0);
    // T3
    look(5, 8'h3B);
    chk("t3_miss", int'(lookup_hit_o), 0);
    upd(5, 8'h3B, 0, 1, 0, 0);
    look(5, 8'h3A);
    chk("t3_hit", int'(lookup_hit_o), 1);
    chk("t3_taken", int'(lookup_taken_o), 0);
    chk("t3_weak", int'(lookup_weak_o), 0);
    // T4
    repeat (4) upd(5, 8'h3A, 0, 0, 1, 0);
    look(5, 8'h3A);
    chk("t4_u_sat", int'(lookup_u_o), 3);
    upd(5, 8'h3A, 0, 0, 1, 1);
    look(5, 8'h3A);
    chk("t4_u_incdec", int'(lookup_u_o), 3);
    // T5
    while (!m_sweep && n_upd < 5000) rnd_upd();
    chk("t5_period", n_upd, PER);
    chk("t5_ready", int'(update_ready_o), 0);
    chk("t5_active", int'(sweep_active_o), 1);
    run_sweep(n);
    chk("t5_sweep_len", n, NE);
    look(5, 8'h3A);
    chk("t5_u_after1", int'(lookup_u_o), 1);
    n0 = n_upd;
    while (!m_sweep && n_upd - n0 < 5000) rnd_upd();
    chk("t5_period2", n_upd - n0, PER);
    run_sweep(n);
    chk("t5_sweep_len2", n, NE);
    look(5, 8'h3A);
    chk("t5_u_after2", int'(lookup_u_o), 0);
    // T6
    lookup_valid_i = 1'b1;
    lookup_index_i = 8'd5;
    lookup_tag_i = 8'h3A;
    upd(5, 8'h3A, 1, 1, 0, 0);
    lookup_valid_i = 1'b0;
    chk("t6_rdw_taken", int'(lookup_taken_o), 0);
    chk("t6_rdw_weak", int'(lookup_weak_o), 0);
    look(5, 8'h3A);
    chk("t6_new_taken", int'(lookup_taken_o), 1);
    chk("t6_new_weak", int'(lookup_weak_o), 1);
    n0 = n_upd;
    while (!m_sweep && n_upd - n0 < 5000) rnd_upd();
    repeat (100) step();
    chk("t6_mid_sweep", int'(sweep_active_o), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_ready", int'(update_ready_o), 1);
    chk("t6_rst_active", int'(sweep_active_o), 0);
    chk("t6_rst_lkvalid", int'(lookup_valid_o), 0);
    for (int i = 0; i < 8; i++) begin
      look(i + 2, i % 4);
      chk("t6_rst_miss", int'(lookup_hit_o), 0);
    end
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
